// File: rtl/pkt_formatter_if.sv
// Arbiter-side and output-bus signals of pkt_formatter, grouped for port binding.
// fmt_parity_o exists only when PKT_FORMATTER_PARITY_EN is defined.
interface pkt_formatter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              f2a_id_req_o;
  logic              f2a_ack_o;
  logic              a2f_val_i;
  logic [1:0]        a2f_id_i;
  logic [DATA_W-1:0] a2f_data_i;
  logic [2:0]        a2f_pkglen_sel_i;
  logic              fmt_req_o;
  logic              fmt_grant_i;
  logic [1:0]        fmt_chid_o;
  logic [5:0]        fmt_length_o;
  logic              fmt_start_o;
  logic [DATA_W-1:0] fmt_data_o;
  logic              fmt_end_o;
`ifdef PKT_FORMATTER_PARITY_EN
  logic              fmt_parity_o;
`endif

  modport master (
    output f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o,
           fmt_start_o, fmt_data_o, fmt_end_o,
`ifdef PKT_FORMATTER_PARITY_EN
    output fmt_parity_o,
`endif
    input  a2f_val_i, a2f_id_i, a2f_data_i, a2f_pkglen_sel_i, fmt_grant_i
  );

  modport slave (
    input  f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o,
           fmt_start_o, fmt_data_o, fmt_end_o,
`ifdef PKT_FORMATTER_PARITY_EN
    input  fmt_parity_o,
`endif
    output a2f_val_i, a2f_id_i, a2f_data_i, a2f_pkglen_sel_i, fmt_grant_i
  );
endinterface

// File: rtl/pkt_formatter.sv
// Packet formatter: requests a channel from the arbiter, buffers one packet, then
// emits it on the output bus with start/end framing. Optional PKT_FORMATTER_PARITY_EN.
module pkt_formatter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BUF_DEPTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pkt_formatter_if.master bus
);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_REQ, S_ID_CHK, S_FILL, S_BUS_REQ, S_SEND
  } state_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic [5:0]        r_cnt, r_len;
  logic [1:0]        r_chid;
  logic              r_id_req, r_req, r_start, r_end;
  logic [DATA_W-1:0] r_data;

  logic              w_full, w_ack, w_rd, w_cnt_last, w_cnt_prelast;
  logic [5:0]        w_len_dec;
  logic [DATA_W-1:0] w_rd_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_len_dec = 6'd32;
    case (bus.a2f_pkglen_sel_i)
      3'd0:    w_len_dec = 6'd4;
      3'd1:    w_len_dec = 6'd8;
      3'd2:    w_len_dec = 6'd16;
      default: w_len_dec = 6'd32;
    endcase
  end

  assign w_full        = (r_occ == OCC_W'(BUF_DEPTH));
  assign w_ack         = (r_state == S_FILL) && bus.a2f_val_i && !w_full;
  assign w_cnt_last    = (r_cnt == r_len - 6'd1);
  assign w_cnt_prelast = (r_cnt == r_len - 6'd2);
  // Word 0 is read on the grant edge so fmt_start_o appears the cycle after grant.
  assign w_rd          = ((r_state == S_BUS_REQ) && bus.fmt_grant_i) ||
                         ((r_state == S_SEND) && !w_cnt_last);
  assign w_rd_word     = r_mem[r_rd_ptr];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = S_ID_REQ;
      S_ID_REQ:  w_next = S_ID_CHK;
      S_ID_CHK:  w_next = (bus.a2f_id_i == 2'd3) ? S_IDLE : S_FILL;
      S_FILL:    if (w_ack && w_cnt_last) w_next = S_BUS_REQ;
      S_BUS_REQ: if (bus.fmt_grant_i) w_next = S_SEND;
      S_SEND:    if (w_cnt_last) w_next = S_ID_REQ;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_ack) r_mem[r_wr_ptr] <= bus.a2f_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_chid   <= '0;
      r_id_req <= 1'b0;
      r_req    <= 1'b0;
      r_start  <= 1'b0;
      r_end    <= 1'b0;
      r_data   <= '0;
    end else begin
      r_state  <= w_next;
      r_id_req <= (w_next == S_ID_REQ);
      r_req    <= (w_next == S_BUS_REQ);
      r_start  <= 1'b0;
      r_end    <= 1'b0;
      if (w_ack) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_ack && !w_rd)      r_occ <= r_occ + OCC_W'(1);
      else if (!w_ack && w_rd) r_occ <= r_occ - OCC_W'(1);
      case (r_state)
        S_ID_CHK: begin
          if (bus.a2f_id_i != 2'd3) begin
            r_chid <= bus.a2f_id_i;
            r_len  <= w_len_dec;
            r_cnt  <= '0;
          end
        end
        S_FILL: begin
          if (w_ack) r_cnt <= r_cnt + 6'd1;
        end
        S_BUS_REQ: begin
          if (bus.fmt_grant_i) begin
            r_cnt   <= '0;
            r_start <= 1'b1;
            r_data  <= w_rd_word;
          end
        end
        S_SEND: begin
          if (w_cnt_last) begin
            r_data <= '0;
          end else begin
            r_cnt  <= r_cnt + 6'd1;
            r_data <= w_rd_word;
            r_end  <= w_cnt_prelast;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PKT_FORMATTER_PARITY_EN
  logic r_acc, r_par;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc <= 1'b0;
      r_par <= 1'b0;
    end else begin
      r_par <= 1'b0;
      if (r_state == S_BUS_REQ && bus.fmt_grant_i) begin
        r_acc <= ^w_rd_word;
      end else if (r_state == S_SEND && !w_cnt_last) begin
        r_acc <= r_acc ^ (^w_rd_word);
        if (w_cnt_prelast) r_par <= r_acc ^ (^w_rd_word);
      end
    end
  end

  assign bus.fmt_parity_o = r_par;
`endif

  assign bus.f2a_id_req_o = r_id_req;
  assign bus.f2a_ack_o    = w_ack;
  assign bus.fmt_req_o    = r_req;
  assign bus.fmt_chid_o   = r_chid;
  assign bus.fmt_length_o = r_len;
  assign bus.fmt_start_o  = r_start;
  assign bus.fmt_data_o   = r_data;
  assign bus.fmt_end_o    = r_end;
endmodule

// File: tb/tb_pkt_formatter.sv
// Scoreboard bench for pkt_formatter with a behavioural arbiter/slave and bus grantor.
module tb_pkt_formatter;
  typedef struct packed {
    logic [1:0]  chid;
    logic [5:0]  len;
    logic        st;
    logic        en;
    logic        par;
    logic [31:0] data;
  } exp_t;

`ifdef PKT_FORMATTER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk_i, rst_i;
  pkt_formatter_if #(.DATA_W(32)) bus_if ();

  pkt_formatter #(.DATA_W(32), .BUF_DEPTH(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  int          n_cmp = 0, n_bad = 0;
  int          ack_cnt = 0, idreq_cnt = 0, pkts_done = 0, grant_delay = 2;
  int unsigned cyc = 0;
  exp_t        exp_q[$];
  logic [31:0] slave_q[$];
  logic [31:0] pkt_words[$];
  logic [1:0]  cfg_id = 2'd3;
  logic [2:0]  cfg_sel = 3'd0;
  logic        stall = 1'b0, spur = 1'b0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Arbiter/slave model: latch id on id request, pop on ack.
  initial begin
    logic ack_s, idr_s;
    bus_if.a2f_val_i        = 1'b0;
    bus_if.a2f_id_i         = 2'd3;
    bus_if.a2f_data_i       = '0;
    bus_if.a2f_pkglen_sel_i = 3'd0;
    forever begin
      @(posedge clk_i);
      ack_s = bus_if.f2a_ack_o;
      idr_s = bus_if.f2a_id_req_o;
      #1;
      if (ack_s) begin
        if (slave_q.size() > 0) void'(slave_q.pop_front());
        ack_cnt++;
      end
      if (idr_s) begin
        bus_if.a2f_id_i         = cfg_id;
        bus_if.a2f_pkglen_sel_i = cfg_sel;
        idreq_cnt++;
      end
      bus_if.a2f_val_i  = (slave_q.size() > 0) && !stall;
      bus_if.a2f_data_i = (slave_q.size() > 0) ? slave_q[0] : 32'h0;
    end
  end

  // Grantor: grant after fmt_req_o has been high for grant_delay+1 cycles.
  initial begin
    int req_cycles;
    req_cycles = 0;
    bus_if.fmt_grant_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (spur) begin
        bus_if.fmt_grant_i = 1'b1;
        spur = 1'b0;
      end else if (bus_if.fmt_req_o) begin
        req_cycles++;
        bus_if.fmt_grant_i = (req_cycles == grant_delay + 1);
      end else begin
        req_cycles = 0;
        bus_if.fmt_grant_i = 1'b0;
      end
    end
  end

  // Monitor: every cycle inside a packet pops one expected word.
  initial begin
    bit   in_pkt;
    exp_t e, a;
    in_pkt = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        in_pkt = 1'b0;
      end else begin
        if (!in_pkt && bus_if.fmt_start_o) in_pkt = 1'b1;
        if (in_pkt) begin
          a.chid = bus_if.fmt_chid_o;
          a.len  = bus_if.fmt_length_o;
          a.st   = bus_if.fmt_start_o;
          a.en   = bus_if.fmt_end_o;
`ifdef PKT_FORMATTER_PARITY_EN
          a.par  = bus_if.fmt_parity_o;
`else
          a.par  = 1'b0;
`endif
          a.data = bus_if.fmt_data_o;
          if (exp_q.size() == 0) begin
            chk("unexpected packet word", 64'(a), 64'h0);
            in_pkt = 1'b0;
          end else begin
            e = exp_q.pop_front();
            chk("pkt word {chid,len,st,en,par,data}", 64'(a), 64'(e));
            if (e.en) begin
              in_pkt = 1'b0;
              pkts_done++;
            end
          end
        end else if (bus_if.fmt_end_o) begin
          chk("spurious fmt_end_o", 64'(bus_if.fmt_end_o), 64'h0);
        end
      end
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, " ctrl {id_req,ack,req,start,end}"},
        64'({bus_if.f2a_id_req_o, bus_if.f2a_ack_o, bus_if.fmt_req_o,
             bus_if.fmt_start_o, bus_if.fmt_end_o}), 64'h0);
    chk({tag, " {chid,length}"}, 64'({bus_if.fmt_chid_o, bus_if.fmt_length_o}), 64'h0);
`ifdef PKT_FORMATTER_PARITY_EN
    chk({tag, " {parity,data}"}, 64'({bus_if.fmt_parity_o, bus_if.fmt_data_o}), 64'h0);
`else
    chk({tag, " data"}, 64'(bus_if.fmt_data_o), 64'h0);
`endif
  endtask

  task automatic load_pkt(input logic [1:0] id, input int len);
    logic [31:0] x;
    exp_t        e;
    x = '0;
    for (int i = 0; i < len; i++) x ^= pkt_words[i];
    for (int i = 0; i < len; i++) begin
      e.chid = id;
      e.len  = 6'(len);
      e.st   = (i == 0);
      e.en   = (i == len - 1);
      e.par  = PAR_EN && (i == len - 1) && (^x);
      e.data = pkt_words[i];
      exp_q.push_back(e);
      slave_q.push_back(pkt_words[i]);
    end
  endtask

  task automatic issue_id(input logic [1:0] id, input logic [2:0] sel);
    int r0, t;
    @(negedge clk_i);
    r0 = idreq_cnt;
    cfg_sel = sel;
    cfg_id  = id;
    t = 0;
    while (idreq_cnt == r0 && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    cfg_id = 2'd3;
    chk("id request seen", 64'(idreq_cnt != r0), 64'h1);
  endtask

  task automatic run_pkt(input logic [1:0] id, input logic [2:0] sel, input int len,
                         input int stall_at, input int stall_len);
    int a0, d0, t;
    a0 = ack_cnt;
    d0 = pkts_done;
    load_pkt(id, len);
    issue_id(id, sel);
    if (stall_len > 0) begin
      t = 0;
      while (ack_cnt - a0 < stall_at && t < 200) begin
        @(negedge clk_i);
        t++;
      end
      stall = 1'b1;
      repeat (stall_len) @(negedge clk_i);
      stall = 1'b0;
    end
    t = 0;
    while (pkts_done == d0 && t < 400) begin
      @(negedge clk_i);
      t++;
    end
    chk("packet completed", 64'(pkts_done != d0), 64'h1);
    chk("ack count", 64'(ack_cnt - a0), 64'(len));
  endtask

  initial begin
    repeat (20000) @(posedge clk_i);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses[$];
    bit saw_req, saw_ack;
    int t;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // No requester: id request every 3 cycles, no bus request, stray grant ignored.
    saw_req = 1'b0;
    saw_ack = 1'b0;
    t = 0;
    while (pulses.size() < 4 && t < 40) begin
      @(negedge clk_i);
      t++;
      if (t == 4) spur = 1'b1;
      if (bus_if.f2a_id_req_o) pulses.push_back(int'(cyc));
      saw_req |= bus_if.fmt_req_o;
      saw_ack |= bus_if.f2a_ack_o;
    end
    chk("retry pulse count", 64'(pulses.size()), 64'd4);
    for (int i = 1; i < pulses.size(); i++)
      chk("retry pulse spacing", 64'(pulses[i] - pulses[i-1]), 64'd3);
    chk("idle fmt_req_o", 64'(saw_req), 64'h0);
    chk("idle f2a_ack_o", 64'(saw_ack), 64'h0);

    pkt_words.delete();
    for (int i = 0; i < 4; i++) pkt_words.push_back(32'h10 + 32'(i));
    run_pkt(2'd1, 3'd0, 4, 0, 0);

    pkt_words.delete();
    for (int i = 0; i < 32; i++) pkt_words.push_back(32'h100 + 32'(i));
    run_pkt(2'd2, 3'd3, 32, 10, 5);

    pkt_words.delete();
    for (int i = 0; i < 32; i++) pkt_words.push_back(32'hA000 + 32'(i));
    run_pkt(2'd0, 3'd6, 32, 0, 0);

    grant_delay = 0;
    pkt_words.delete();
    for (int i = 0; i < 16; i++) pkt_words.push_back(32'h5000 + 32'(i));
    run_pkt(2'd1, 3'd2, 16, 0, 0);
    grant_delay = 2;

    // Reset during word 2 of an 8-word packet.
    pkt_words.delete();
    for (int i = 0; i < 8; i++) pkt_words.push_back(32'h80 + 32'(i));
    load_pkt(2'd1, 8);
    issue_id(2'd1, 3'd1);
    t = 0;
    while (!bus_if.fmt_start_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    chk("truncated pkt start seen", 64'(bus_if.fmt_start_o), 64'h1);
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk_reset_outs("mid-packet reset");
    exp_q.delete();
    slave_q.delete();
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b0;

    pkt_words.delete();
    pkt_words.push_back(32'h1);
    pkt_words.push_back(32'h2);
    pkt_words.push_back(32'h4);
    pkt_words.push_back(32'h8);
    run_pkt(2'd0, 3'd0, 4, 0, 0);

    pkt_words.delete();
    pkt_words.push_back(32'h1);
    pkt_words.push_back(32'h0);
    pkt_words.push_back(32'h0);
    pkt_words.push_back(32'h0);
    run_pkt(2'd2, 3'd0, 4, 0, 0);

    repeat (5) @(negedge clk_i);
    chk("scoreboard drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
